// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared addresses, status bit indices and decode regions for the data-side responder
package mips_mem_pkg;

    localparam logic [31:0] CONSOLE_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_ADDR  = 32'hFFFF_0004;
    localparam logic [31:0] CYCLE_ADDR   = 32'hFFFF_0008;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CONSOLE,
        REG_STATUS,
        REG_CYCLE,
        REG_NONE
    } region_e;

endpackage

// File: rtl/mips_data_mem_responder_byte_fifo.sv
// rtl/mips_data_mem_responder_byte_fifo.sv - byte FIFO backing the console transmit path
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          drop_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge:
    // the slot being written is exactly the one being vacated.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    // Next-state for pointers and occupancy; pointers wrap on their natural width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mips_data_mem_responder.sv
// rtl/mips_data_mem_responder.sv - data RAM plus console/status/cycle I/O page for the CPU data port
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_error
);

    localparam int          IW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_LIMIT = {1'b0, RAM_BASE} + 33'(RAM_WORDS) * 33'd4;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [31:0]   word_addr;
    logic [IW-1:0] ram_idx;
    region_e       region;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count8;
    logic [31:0]   status_word;

    logic          ovf_q, ovf_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   cycle_q, cycle_d;

    assign word_addr = data_address & ~32'h3;
    assign ram_idx   = data_address[IW+1:2] - RAM_BASE[IW+1:2];

    // Decode the word address into one of the mapped regions.
    always_comb begin
        region = REG_NONE;
        if ({1'b0, word_addr} >= {1'b0, RAM_BASE} && {1'b0, word_addr} < RAM_LIMIT)
            region = REG_RAM;
        else if (word_addr == CONSOLE_ADDR)
            region = REG_CONSOLE;
        else if (word_addr == STATUS_ADDR)
            region = REG_STATUS;
        else if (word_addr == CYCLE_ADDR)
            region = REG_CYCLE;
    end

    assign fifo_push = data_write && (region == REG_CONSOLE) && byte_enable[0];
    assign fifo_pop  = tx_valid && tx_ready;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (fifo_push),
        .push_data_i(data_writedata[7:0]),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .drop_o     (fifo_drop)
    );

    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_head;
    assign bus_error = bus_err_q;
    assign count8    = 8'(fifo_count);

    // Assemble the status register from live FIFO state and the overflow flag.
    always_comb begin
        status_word             = {16'h0, count8, 8'h0};
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_OVF]   = ovf_q;
    end

    // Load data mux; shows pre-write state when a read and write share a cycle.
    always_comb begin
        data_readdata = 32'h0;
        if (data_read) begin
            case (region)
                REG_RAM:     data_readdata = ram_q[ram_idx];
                REG_CONSOLE: data_readdata = fifo_empty ? 32'h0 : {24'h0, fifo_head};
                REG_STATUS:  data_readdata = status_word;
                REG_CYCLE:   data_readdata = cycle_q;
                default:     data_readdata = 32'h0;
            endcase
        end
    end

    // Next state for sticky flags and the free-running counter; a drop wins over a same-edge clear.
    always_comb begin
        ovf_d     = ovf_q;
        bus_err_d = bus_err_q;
        cycle_d   = cycle_q + 32'd1;
        if (data_write && (region == REG_STATUS) && byte_enable[0] && data_writedata[STAT_OVF])
            ovf_d = 1'b0;
        if (fifo_drop)
            ovf_d = 1'b1;
        if ((data_read || data_write) && (region == REG_NONE))
            bus_err_d = 1'b1;
    end

    // Flag and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q     <= 1'b0;
            bus_err_q <= 1'b0;
            cycle_q   <= 32'h0;
        end else begin
            ovf_q     <= ovf_d;
            bus_err_q <= bus_err_d;
            cycle_q   <= cycle_d;
        end
    end

    // Byte-lane RAM writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (data_write && (region == REG_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enable[i]) ram_q[ram_idx][8*i +: 8] <= data_writedata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// tb/tb_mips_data_mem_responder.sv - self-checking bench for mips_data_mem_responder
module tb_mips_data_mem_responder;

    localparam logic [31:0] CON = 32'hFFFF_0000;
    localparam logic [31:0] STA = 32'hFFFF_0004;
    localparam logic [31:0] CYC = 32'hFFFF_0008;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        rd;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_tx;
        logic [7:0]  exp_tx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_address;
    logic        data_write, data_read;
    logic [3:0]  byte_enable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, bus_error;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic        m_berr;
    logic [31:0] m_cycle;

    vec_t vecs [$];

    mips_data_mem_responder dut (
        .clk           (clk),
        .reset         (rst_n),
        .data_address  (data_address),
        .data_write    (data_write),
        .data_read     (data_read),
        .byte_enable   (byte_enable),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .bus_error     (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic wr, input logic rd,
                                input logic [3:0] be, input logic [31:0] wd, input logic rdy,
                                input logic chk_rd, input logic [31:0] exp_rd,
                                input logic chk_tx, input logic [7:0] exp_tx);
        vec_t v;
        v.addr = a; v.wr = wr; v.rd = rd; v.be = be; v.wd = wd; v.rdy = rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_tx = chk_tx; v.exp_tx = exp_tx;
        return v;
    endfunction

    // 0=RAM 1=console 2=status 3=cycle 4=unmapped
    function automatic int m_region(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w >= 32'h1000 && w < 32'h1000 + 32'd4096) return 0;
        if (w == CON) return 1;
        if (w == STA) return 2;
        if (w == CYC) return 3;
        return 4;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(((a & ~32'h3) - 32'h1000) / 4);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = {16'h0, 8'(m_q.size()), 8'h0};
        s[0] = (m_q.size() == 0);
        s[1] = (m_q.size() == 8);
        s[2] = m_ovf;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd, output logic known);
        known = 1'b1;
        if (!rd) return 32'h0;
        case (m_region(a))
            0: begin
                if (m_ram.exists(m_idx(a))) return m_ram[m_idx(a)];
                known = 1'b0;
                return 32'h0;
            end
            1: return (m_q.size() == 0) ? 32'h0 : {24'h0, m_q[0]};
            2: return m_status();
            3: return m_cycle;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_berr  = 1'b0;
        m_cycle = 32'h0;
    endtask

    task automatic m_edge(input vec_t v);
        int  r;
        bit  pop, push;
        r    = m_region(v.addr);
        pop  = (m_q.size() != 0) && v.rdy;
        push = v.wr && (r == 1) && v.be[0];
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 8) m_q.push_back(v.wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (v.wr && r == 2 && v.be[0] && v.wd[2]) m_ovf = 1'b0;
        if ((v.wr || v.rd) && r == 4) m_berr = 1'b1;
        if (v.wr && r == 0) begin
            logic [31:0] w;
            w = m_ram.exists(m_idx(v.addr)) ? m_ram[m_idx(v.addr)] : 32'h0;
            for (int i = 0; i < 4; i++) if (v.be[i]) w[8*i +: 8] = v.wd[8*i +: 8];
            if (v.be != 4'h0 || m_ram.exists(m_idx(v.addr))) begin
                if (v.be == 4'hF || m_ram.exists(m_idx(v.addr))) m_ram[m_idx(v.addr)] = w;
            end
        end
        m_cycle = m_cycle + 32'd1;
    endtask

    // One bus cycle: drive just after a rising edge, compare at the falling edge, commit at the next rising edge.
    task automatic step(input vec_t v);
        logic [31:0] exp;
        logic        known;
        data_address   = v.addr;
        data_write     = v.wr;
        data_read      = v.rd;
        byte_enable    = v.be;
        data_writedata = v.wd;
        tx_ready       = v.rdy;
        @(negedge clk);
        exp = m_read(v.addr, v.rd, known);
        if (known) check("readdata", data_readdata, exp);
        check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
        check("bus_error", 32'(bus_error), 32'(m_berr));
        if (v.chk_rd) check("readdata_vec", data_readdata, v.exp_rd);
        if (v.chk_tx) check("tx_data_vec", 32'(tx_data), 32'(v.exp_tx));
        @(posedge clk);
        m_edge(v);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(mk(32'h0, 0, 0, 4'h0, 32'h0, rdy, 0, 32'h0, 0, 8'h0));
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        data_address = CYC; data_write = 0; data_read = 1; byte_enable = 0;
        data_writedata = 0; tx_ready = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_bus_error", 32'(bus_error), 32'h0);
        check("reset_cycle", data_readdata, 32'h0);
        rst_n = 1'b1;

        // Directed table
        vecs.push_back(mk(32'h1000, 1, 0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h1000, 1, 0, 4'b0010, 32'h0000_5500, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h1000, 0, 1, 4'h0, 0, 0, 1, 32'hDEAD55EF, 0, 0));
        vecs.push_back(mk(32'h1000, 0, 0, 4'h0, 0, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(32'h1003, 0, 1, 4'h0, 0, 0, 1, 32'hDEAD55EF, 0, 0));
        vecs.push_back(mk(CYC, 1, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(CON, 1, 0, 4'h1, 32'h41, 0, 0, 0, 0, 0));
        vecs.push_back(mk(CON, 1, 0, 4'h1, 32'h42, 0, 0, 0, 0, 0));
        vecs.push_back(mk(CON, 1, 0, 4'h1, 32'h43, 0, 0, 0, 0, 0));
        vecs.push_back(mk(CON, 1, 0, 4'hE, 32'h44, 0, 0, 0, 0, 0));
        vecs.push_back(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0300, 0, 0));
        vecs.push_back(mk(CON, 0, 1, 4'h0, 0, 0, 1, 32'h41, 0, 0));
        vecs.push_back(mk(32'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 8'h41));
        vecs.push_back(mk(32'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 8'h42));
        vecs.push_back(mk(32'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 8'h43));
        vecs.push_back(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0001, 0, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(CON, 1, 0, 4'h1, 32'h50 + 32'(i), 0, 0, 0, 0, 0));
        vecs.push_back(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0806, 0, 0));
        vecs.push_back(mk(STA, 1, 0, 4'h1, 32'h4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0802, 0, 0));
        vecs.push_back(mk(CON, 1, 0, 4'h1, 32'h99, 1, 0, 0, 1, 8'h50));
        vecs.push_back(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0802, 0, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(32'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 8'h51 + 8'(i)));
        vecs.push_back(mk(32'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 8'h99));
        vecs.push_back(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0001, 0, 0));
        vecs.push_back(mk(32'h1FFC, 1, 0, 4'hF, 32'h12345678, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h1FFC, 0, 1, 4'h0, 0, 0, 1, 32'h12345678, 0, 0));
        vecs.push_back(mk(32'h1000, 1, 1, 4'hF, 32'h0BADF00D, 0, 1, 32'hDEAD55EF, 0, 0));
        vecs.push_back(mk(32'h1000, 1, 1, 4'hF, 32'hDEAD55EF, 0, 1, 32'h0BADF00D, 0, 0));
        vecs.push_back(mk(32'h0FFC, 0, 1, 4'h0, 0, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(32'h2000, 1, 0, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h1000, 0, 1, 4'h0, 0, 0, 1, 32'hDEAD55EF, 0, 0));
        vecs.push_back(mk(32'h1FFC, 0, 1, 4'h0, 0, 0, 1, 32'h12345678, 0, 0));
        foreach (vecs[i]) step(vecs[i]);
        check("bus_error_sticky", 32'(bus_error), 32'h1);

        // Reset mid-drain
        for (int i = 0; i < 3; i++)
            step(mk(CON, 1, 0, 4'h1, 32'h60 + 32'(i), 0, 0, 0, 0, 0));
        idle(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_async_bus_error", 32'(bus_error), 32'h0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(CYC, 0, 1, 4'h0, 0, 0, 1, 32'h0, 0, 0));
        step(mk(CYC, 0, 1, 4'h0, 0, 0, 1, 32'h1, 0, 0));
        step(mk(32'h1000, 0, 1, 4'h0, 0, 0, 1, 32'hDEAD55EF, 0, 0));
        step(mk(STA, 0, 1, 4'h0, 0, 0, 1, 32'h0000_0001, 0, 0));

        // Seed a known set of RAM words, then randomised traffic against the model
        for (int k = 0; k < 8; k++)
            step(mk(32'h1000 + 32'(4 * k), 1, 0, 4'hF, $urandom, 0, 0, 0, 0, 0));
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4: v.addr = 32'h1000 + 32'(4 * $urandom_range(0, 7));
                5:       v.addr = 32'h1FFC;
                6:       v.addr = CON;
                7:       v.addr = STA;
                8:       v.addr = CYC;
                default: v.addr = ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'h0FFC;
            endcase
            v.addr   = v.addr | 32'($urandom_range(0, 3));
            v.wr     = ($urandom_range(0, 1) == 1);
            v.rd     = ($urandom_range(0, 9) < 7);
            v.be     = 4'($urandom);
            v.wd     = $urandom;
            v.rdy    = ($urandom_range(0, 2) == 0);
            v.chk_rd = 0; v.exp_rd = 0; v.chk_tx = 0; v.exp_tx = 0;
            if (sel >= 9 && n < 350) begin
                v.wr = 0;
                v.rd = 0;
            end
            step(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_data_mem_responder.md
Name: mips_data_mem_responder

Overview:
Responder for the Harvard CPU data port. It implements a byte-enabled data RAM and a small memory-mapped I/O page. The I/O page holds a console transmit FIFO with a valid/ready drain, a status register and a free-running cycle counter. It sits between the CPU's data_* outputs and the system/testbench, and is the standard data-side memory for simulation and FPGA builds.

Parameters:
RAM_BASE, 32'h0000_1000, byte address of RAM word 0; must be word-aligned.
RAM_WORDS, 1024, RAM depth in 32-bit words; must be a power of two.
FIFO_DEPTH, 8, console FIFO depth in bytes; must be a power of two and at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
data_address  input  32  byte address from the CPU; bits [1:0] are ignored.
data_write  input  1  write strobe for the current cycle.
data_read  input  1  read strobe for the current cycle.
byte_enable  input  4  lane mask; lane i is data bits [8i+7:8i].
data_writedata  input  32  store data.
data_readdata  output  32  load data; combinational, same cycle as the request.
tx_data  output  8  byte at the head of the console FIFO.
tx_valid  output  1  FIFO is not empty.
tx_ready  input  1  consumer accepts tx_data this cycle.
bus_error  output  1  sticky flag: an access hit an unmapped address.

Behaviour:
Reset (reset=0, asynchronous):
- FIFO pointers and count clear to 0; tx_valid=0.
- Overflow flag=0, bus_error=0, cycle counter=0.
- RAM contents are not cleared.

Address decode, word address A = data_address with bits [1:0] forced to 0:
- RAM: RAM_BASE <= A < RAM_BASE+4*RAM_WORDS; index = (A-RAM_BASE)>>2.
- CONSOLE at 32'hFFFF_0000, STATUS at 32'hFFFF_0004, CYCLE at 32'hFFFF_0008.
- Any other address is unmapped.

Reads (combinational):
- data_readdata is valid only while data_read=1; otherwise it is 32'h0.
- RAM read returns the full stored word; byte_enable is ignored, and the CPU extracts lanes.
- CONSOLE read returns {24'h0, head byte}, or 0 if the FIFO is empty. Reading does not pop.
- STATUS read returns {16'h0, count[7:0], 5'h0, overflow, full, empty}. Count is zero-extended.
- CYCLE read returns the counter value.
- Unmapped read returns 32'h0 and sets bus_error at the next edge.

Writes (rising edge, data_write=1):
- RAM: each lane with byte_enable[i]=1 is written; other lanes are preserved. byte_enable=0 is a no-op.
- CONSOLE: a push of data_writedata[7:0] happens only when byte_enable[0]=1.
- STATUS: writing 1 to bit 2 with byte_enable[0]=1 clears overflow; all other bits are ignored.
- CYCLE: writes are ignored and do not raise an error.
- Unmapped write: no state change except setting bus_error.
- data_read and data_write together: the write commits at the edge, and data_readdata shows the pre-write value during that cycle.

Console FIFO:
- Pop occurs on an edge where tx_valid=1 and tx_ready=1; tx_data is the head byte and is stable while tx_valid=1 and no pop occurs.
- Push while not full: the byte is stored and count increments.
- Push while full with no pop: the byte is dropped and overflow is set (sticky).
- Push and pop on the same edge: both occur, and count is unchanged. This also applies when full, with no overflow.
- A push into an empty FIFO gives tx_valid=1 from the next cycle; there is no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH.
- full = (count==FIFO_DEPTH); empty = (count==0).

Counters and flags:
- The cycle counter increments every clk edge out of reset and wraps FFFF_FFFF to 0.
- bus_error is cleared only by reset.

Decomposition:
- Package mips_mem_pkg holds CONSOLE_ADDR, STATUS_ADDR, CYCLE_ADDR, the STATUS bit indices (EMPTY=0, FULL=1, OVF=2) and a region enum {REG_RAM, REG_CONSOLE, REG_STATUS, REG_CYCLE, REG_NONE}.
- One sub-module, byte_fifo: parameterised depth, push/pop, full/empty/count, async active-low reset. The top holds the decoder, RAM array and counter.

Test Plan:
- Write 32'hDEADBEEF to 0x1000 with byte_enable=4'hF, then write 0x1000 with byte_enable=4'b0010 and data 32'h0000_5500; read 0x1000 → 32'hDEAD55EF.
- Write bytes 0x41,0x42,0x43 to CONSOLE with tx_ready=0; STATUS reads 32'h0000_0300. Raise tx_ready: tx_data is 0x41,0x42,0x43 on successive cycles, then tx_valid=0 and STATUS=32'h1.
- Fill 8 bytes and push a 9th with tx_ready=0: STATUS=32'h0000_0806 and the 9th byte is lost. Write 4 to STATUS: overflow=0.
- With the FIFO full, push and pop on the same edge: count stays 8, overflow stays 0, and the new byte drains last.
- Read 0x0000_0FFC, then write 0x2000 (RAM_WORDS=1024): data_readdata=0, bus_error=1 next cycle, and RAM is unchanged.
- Assert reset low mid-drain: tx_valid drops immediately, CYCLE reads 0 after release, and RAM data written before reset is still readable.
